// File: rtl/cache_pkg.sv
// Shared types for the cache request sequencer: FSM states and the
// buffered request entry layout.
package cache_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_entry_t;

    localparam int REQ_ENTRY_W = $bits(req_entry_t);

endpackage

// File: rtl/cache_req_sequencer_if.sv
// Request / cache / response bundle of the cache request sequencer.
// The sequencer sits on the slave side; the CPU plus done logic form the master.
interface cache_req_sequencer_if;
    import cache_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  cache_re;
    logic                  cache_we;
    logic [ADDR_WIDTH-1:0] cache_addr;
    logic [DATA_WIDTH-1:0] cache_wdata;
    logic [DATA_WIDTH-1:0] cache_rdata;
    logic                  op_in_progress;
    logic                  done;
    logic                  resp_valid;
    logic                  resp_we;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic                  err_sticky;
    logic                  err_clear;
    logic                  busy;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  cache_rdata, op_in_progress, done, err_clear,
        output req_ready, cache_re, cache_we, cache_addr, cache_wdata,
        output resp_valid, resp_we, resp_rdata, resp_err, err_sticky, busy
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output cache_rdata, op_in_progress, done, err_clear,
        input  req_ready, cache_re, cache_we, cache_addr, cache_wdata,
        input  resp_valid, resp_we, resp_rdata, resp_err, err_sticky, busy
    );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with extra-MSB pointers; head is shown without a pop.
// Push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_head  = r_mem[r_rptr[AW-1:0]];

    // Advance read/write pointers; they wrap modulo 2*DEPTH.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage; contents are don't-care while the slot is free.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/cache_req_sequencer.sv
// Buffers CPU requests and issues them one at a time to the cache done logic,
// holding address/data until done (or a timeout) and returning a 1-cycle response.
module cache_req_sequencer
    import cache_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_req_sequencer_if.slave  bus
);
    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t            r_state;
    seq_state_t            w_next;
    logic                  w_timeout;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_full;
    logic                  w_empty;
    logic [REQ_ENTRY_W-1:0] w_head_bits;
    req_entry_t            w_head;
    req_entry_t            w_push_entry;

    logic                  r_cache_re;
    logic                  r_cache_we;
    logic [ADDR_WIDTH-1:0] r_cache_addr;
    logic [DATA_WIDTH-1:0] r_cache_wdata;
    logic                  r_resp_valid;
    logic                  r_resp_we;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic                  r_resp_err;
    logic                  r_err_sticky;

    assign w_push_entry = {bus.req_we, bus.req_addr, bus.req_wdata};
    assign w_head       = req_entry_t'(w_head_bits);

    sync_fifo #(
        .WIDTH (REQ_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (bus.req_valid),
        .i_pop   (r_state == RESP),
        .i_wdata (w_push_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head_bits)
    );

    // Next-state decode; done takes priority over the timeout terminal count.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !bus.op_in_progress) begin
                    w_next = ISSUE;
                end else begin
                    w_next = IDLE;
                end
            end
            ISSUE: w_next = WAIT;
            WAIT: begin
                if (bus.done) begin
                    w_next = RESP;
                end else if (r_cnt == CNT_MAX) begin
                    w_next    = RESP;
                    w_timeout = 1'b1;
                end else begin
                    w_next = WAIT;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Cycles spent in WAIT; restarted on every issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_cnt <= '0;
        end else if ((r_state == WAIT) && (w_next == WAIT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Registered cache/response outputs, computed from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cache_re    <= 1'b0;
            r_cache_we    <= 1'b0;
            r_cache_addr  <= '0;
            r_cache_wdata <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_we     <= 1'b0;
            r_resp_rdata  <= '0;
            r_resp_err    <= 1'b0;
        end else begin
            r_cache_re    <= (w_next == ISSUE) && !w_head.we;
            r_cache_we    <= (w_next == ISSUE) && w_head.we;
            r_cache_addr  <= (w_next != IDLE) ? w_head.addr  : '0;
            r_cache_wdata <= (w_next != IDLE) ? w_head.wdata : '0;
            r_resp_valid  <= (w_next == RESP);
            r_resp_we     <= (w_next == RESP) && w_head.we;
            r_resp_rdata  <= ((w_next == RESP) && !w_timeout && !w_head.we) ? bus.cache_rdata : '0;
            r_resp_err    <= w_timeout;
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
        end else if (w_timeout) begin
            r_err_sticky <= 1'b1;
        end else if (bus.err_clear) begin
            r_err_sticky <= 1'b0;
        end
    end

    assign bus.req_ready   = !w_full;
    assign bus.busy        = !w_empty || (r_state != IDLE);
    assign bus.cache_re    = r_cache_re;
    assign bus.cache_we    = r_cache_we;
    assign bus.cache_addr  = r_cache_addr;
    assign bus.cache_wdata = r_cache_wdata;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_we     = r_resp_we;
    assign bus.resp_rdata  = r_resp_rdata;
    assign bus.resp_err    = r_resp_err;
    assign bus.err_sticky  = r_err_sticky;

endmodule

// File: tb/tb_cache_req_sequencer.sv
// Directed bench for cache_req_sequencer with a response scoreboard.
module tb_cache_req_sequencer;
    import cache_pkg::*;

    typedef struct {
        logic       we;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_resp   = 0;
    int   cyc      = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    cache_req_sequencer_if bus ();

    cache_req_sequencer #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Drive one request for a cycle and record its expected response.
    task automatic push_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                            input logic [7:0] exp_rdata, input logic exp_err);
        exp_t e;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        e.we    = we;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb.push_back(e);
        step();
        bus.req_valid = 1'b0;
    endtask

    // Scoreboard: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.resp_valid === 1'b1) begin
            n_resp++;
            chk1("resp_expected_pending", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk1("sb_resp_we", bus.resp_we, e.we);
                chk8("sb_resp_rdata", bus.resp_rdata, e.rdata);
                chk1("sb_resp_err", bus.resp_err, e.err);
            end
        end
    end

    initial begin
        int         prev_issue;
        int         snap;
        bit         found;
        logic [7:0] a;

        bus.req_valid = 1'b0;  bus.req_we = 1'b0;  bus.req_addr = 8'h00;  bus.req_wdata = 8'h00;
        bus.cache_rdata = 8'h00; bus.op_in_progress = 1'b0; bus.done = 1'b0; bus.err_clear = 1'b0;

        // Reset values
        repeat (3) step();
        chk1("rst_ready", bus.req_ready, 1'b1);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_re", bus.cache_re, 1'b0);
        chk1("rst_we", bus.cache_we, 1'b0);
        chk1("rst_resp_valid", bus.resp_valid, 1'b0);
        chk1("rst_sticky", bus.err_sticky, 1'b0);
        rst = 1'b0;
        step();

        // Single read: issue at T+2, response at T+5, idle at T+6
        push_req(1'b0, 8'h12, 8'h00, 8'hA5, 1'b0);
        chk1("rd_re_t1", bus.cache_re, 1'b0);
        chk1("rd_busy_t1", bus.busy, 1'b1);
        step();
        chk1("rd_re_t2", bus.cache_re, 1'b1);
        chk1("rd_we_t2", bus.cache_we, 1'b0);
        chk8("rd_addr_t2", bus.cache_addr, 8'h12);
        step();
        chk1("rd_re_t3", bus.cache_re, 1'b0);
        chk8("rd_addr_t3", bus.cache_addr, 8'h12);
        step();
        chk8("rd_addr_t4", bus.cache_addr, 8'h12);
        bus.done = 1'b1; bus.cache_rdata = 8'hA5;
        step();
        bus.done = 1'b0; bus.cache_rdata = 8'h00;
        chk1("rd_resp_valid", bus.resp_valid, 1'b1);
        chk1("rd_resp_we", bus.resp_we, 1'b0);
        chk8("rd_resp_rdata", bus.resp_rdata, 8'hA5);
        step();
        chk1("rd_busy_t6", bus.busy, 1'b0);
        chk8("rd_rdata_cleared", bus.resp_rdata, 8'h00);
        chk8("rd_addr_idle", bus.cache_addr, 8'h00);

        // Write: one cache_we pulse, wdata held, response rdata 0
        push_req(1'b1, 8'h03, 8'h7E, 8'h00, 1'b0);
        step();
        chk1("wr_we_pulse", bus.cache_we, 1'b1);
        chk1("wr_re", bus.cache_re, 1'b0);
        chk8("wr_addr", bus.cache_addr, 8'h03);
        chk8("wr_wdata_issue", bus.cache_wdata, 8'h7E);
        step();
        chk1("wr_we_low", bus.cache_we, 1'b0);
        chk8("wr_wdata_wait", bus.cache_wdata, 8'h7E);
        step();
        chk8("wr_wdata_wait2", bus.cache_wdata, 8'h7E);
        bus.done = 1'b1; bus.cache_rdata = 8'hFF;
        step();
        bus.done = 1'b0; bus.cache_rdata = 8'h00;
        chk1("wr_resp_valid", bus.resp_valid, 1'b1);
        chk1("wr_resp_we", bus.resp_we, 1'b1);
        chk8("wr_resp_rdata", bus.resp_rdata, 8'h00);
        step();

        // Stray done in IDLE
        bus.done = 1'b1;
        step();
        chk1("stray_idle_resp", bus.resp_valid, 1'b0);
        step();
        bus.done = 1'b0;
        chk1("stray_idle_resp2", bus.resp_valid, 1'b0);
        chk1("stray_idle_busy", bus.busy, 1'b0);

        // Stray done in IDLE(non-empty)/ISSUE, then the request times out
        push_req(1'b0, 8'h55, 8'h00, 8'h00, 1'b1);
        bus.done = 1'b1;
        step();
        chk1("to_issue_re", bus.cache_re, 1'b1);
        step();
        bus.done = 1'b0;
        chk1("to_wait_entry_resp", bus.resp_valid, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            step();
            chk1("to_wait_no_resp", bus.resp_valid, 1'b0);
        end
        step();
        chk1("to_resp_valid", bus.resp_valid, 1'b1);
        chk1("to_resp_err", bus.resp_err, 1'b1);
        chk8("to_resp_rdata", bus.resp_rdata, 8'h00);
        chk1("to_sticky_set", bus.err_sticky, 1'b1);
        step();
        chk1("to_err_cleared", bus.resp_err, 1'b0);
        chk1("to_sticky_hold", bus.err_sticky, 1'b1);
        chk1("to_busy_after", bus.busy, 1'b0);
        bus.err_clear = 1'b1;
        step();
        bus.err_clear = 1'b0;
        chk1("to_sticky_clear", bus.err_sticky, 1'b0);

        // Done on the timeout terminal cycle: done wins
        push_req(1'b0, 8'h44, 8'h00, 8'h3C, 1'b0);
        step();
        chk1("term_issue_re", bus.cache_re, 1'b1);
        step();
        repeat (15) step();
        bus.done = 1'b1; bus.cache_rdata = 8'h3C;
        step();
        bus.done = 1'b0; bus.cache_rdata = 8'h00;
        chk1("term_resp_valid", bus.resp_valid, 1'b1);
        chk1("term_resp_err", bus.resp_err, 1'b0);
        chk8("term_resp_rdata", bus.resp_rdata, 8'h3C);
        chk1("term_sticky", bus.err_sticky, 1'b0);
        step();

        // Fill with op_in_progress high, then drain in order
        bus.op_in_progress = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk1("fill_ready_before", bus.req_ready, 1'b1);
            a = 8'h20 + 8'(i);
            push_req(1'(i % 2), a, 8'h90 + 8'(i), (i % 2 == 1) ? 8'h00 : (a ^ 8'h5A), 1'b0);
        end
        chk1("fill_ready_full", bus.req_ready, 1'b0);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 8'h2F; bus.req_wdata = 8'h00;
        step();
        bus.req_valid = 1'b0;
        chk1("fill_ready_full2", bus.req_ready, 1'b0);
        repeat (3) begin
            chk1("fill_no_issue", bus.cache_re | bus.cache_we, 1'b0);
            step();
        end
        bus.op_in_progress = 1'b0;
        prev_issue = 0;
        for (int i = 0; i < 4; i++) begin
            found = 1'b0;
            for (int k = 0; k < 10; k++) begin
                if (bus.cache_re === 1'b1 || bus.cache_we === 1'b1) begin
                    found = 1'b1;
                    break;
                end
                step();
            end
            chk1("fill_issue_seen", found, 1'b1);
            chk8("fill_addr", bus.cache_addr, 8'h20 + 8'(i));
            chk8("fill_wdata", bus.cache_wdata, 8'h90 + 8'(i));
            chk1("fill_dir", bus.cache_we, 1'(i % 2));
            if (i > 0) chki("fill_spacing", cyc - prev_issue, 4);
            prev_issue = cyc;
            step();
            bus.done = 1'b1; bus.cache_rdata = bus.cache_addr ^ 8'h5A;
            step();
            bus.done = 1'b0; bus.cache_rdata = 8'h00;
            chk1("fill_resp_valid", bus.resp_valid, 1'b1);
            if (i == 0) chk1("fill_ready_in_resp", bus.req_ready, 1'b0);
            step();
            if (i == 0) chk1("fill_ready_after_resp", bus.req_ready, 1'b1);
        end
        repeat (6) step();
        chk1("fill_fifth_dropped", bus.busy, 1'b0);
        chki("fill_sb_drained", sb.size(), 0);
        chki("resp_count", n_resp, 8);

        // Reset in the middle of WAIT drops everything
        push_req(1'b0, 8'h66, 8'h00, 8'h77, 1'b0);
        step();
        step();
        chk8("rstw_addr_before", bus.cache_addr, 8'h66);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        chk8("rstw_addr", bus.cache_addr, 8'h00);
        chk1("rstw_busy", bus.busy, 1'b0);
        chk1("rstw_ready", bus.req_ready, 1'b1);
        bus.done = 1'b1; bus.cache_rdata = 8'h77;
        step();
        step();
        bus.done = 1'b0; bus.cache_rdata = 8'h00;
        rst = 1'b0;
        snap = n_resp;
        repeat (20) step();
        chki("rstw_no_resp", n_resp - snap, 0);
        chk1("rstw_busy_after", bus.busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/cache_req_sequencer.md
Name: cache_req_sequencer

Overview:
Front-end stage directly upstream of the cache done-generation logic. It buffers CPU read/write requests in a small FIFO and issues them to the cache one at a time as single-cycle re/we pulses. It holds address and write data stable until the done-generator reports completion, then returns a one-cycle response carrying read data. A per-request timeout guards against a done that never arrives.

Parameters:
ADDR_WIDTH, 8, request/cache address width
DATA_WIDTH, 8, read/write data width
FIFO_DEPTH, 4, request buffer entries; power of 2, >=2
TIMEOUT_CYCLES, 16, maximum cycles in WAIT before timeout; >=4

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  CPU request present
req_ready  out  1  request buffer can accept (= not full)
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data (ignored for reads)
cache_re  out  1  one-cycle read issue to cache/done logic
cache_we  out  1  one-cycle write issue to cache/done logic
cache_addr  out  ADDR_WIDTH  address of in-flight request
cache_wdata  out  DATA_WIDTH  write data of in-flight request
cache_rdata  in  DATA_WIDTH  cache read data, valid when done=1
op_in_progress  in  1  done logic busy; blocks issue
done  in  1  completion pulse from done logic
resp_valid  out  1  one-cycle response pulse
resp_we  out  1  response belongs to a write
resp_rdata  out  DATA_WIDTH  captured read data (0 for writes/timeouts)
resp_err  out  1  response is a timeout
err_sticky  out  1  a timeout has occurred since reset/clear
err_clear  in  1  clears err_sticky
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async, immediate): FIFO empty, FSM=IDLE, timeout counter 0. All outputs 0 except req_ready=1.
- FIFO: push on req_valid&req_ready. req_ready = !full from registered state only; no same-cycle push-when-full even if a pop occurs. Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH. Entry = {we, addr, wdata}. Head is popped only on completion or timeout.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if !empty & !op_in_progress, go to ISSUE; otherwise stay.
- ISSUE (exactly 1 cycle): cache_re = !head.we, cache_we = head.we; go to WAIT. Timeout counter is cleared.
- WAIT: cache_re = cache_we = 0. If done, capture cache_rdata (reads only) into resp_rdata and go to RESP. Otherwise the counter increments. When counter = TIMEOUT_CYCLES-1 without done, set resp_err and err_sticky, and go to RESP.
- RESP (exactly 1 cycle): resp_valid=1; resp_we, resp_rdata and resp_err are valid. FIFO pop occurs at this edge. Go to IDLE. resp_rdata and resp_err clear to 0 on the next cycle.
- cache_addr/cache_wdata are driven from the FIFO head in ISSUE, WAIT and RESP; 0 in IDLE.
- done is ignored outside WAIT; no response is generated for it.
- done on the same cycle as the timeout terminal count: done wins, no error.
- Minimum issue-to-issue spacing is 4 cycles (IDLE, ISSUE, WAIT, RESP). Back-to-back issue additionally waits for op_in_progress=0.
- err_clear and a simultaneous new timeout: set wins.
- A push during RESP with the FIFO full is not accepted (ready=0).
- rst mid-WAIT: the in-flight request and all buffered requests are dropped; no response is produced.

Decomposition:
- Shared package cache_pkg holds: seq_state_t enum {IDLE, ISSUE, WAIT, RESP}, and a req_entry_t packed struct {we, addr, wdata} sized from package constants ADDR_WIDTH/DATA_WIDTH.
- One sub-module, sync_fifo (parameterised WIDTH, DEPTH; push/pop/full/empty/head), is instantiated for the request buffer.
- FSM and timeout counter stay in cache_req_sequencer.

Test Plan:
- Reset: after rst, req_ready=1, busy=0, cache_re=cache_we=resp_valid=0; rst asserted mid-WAIT takes effect immediately, and no resp_valid follows.
- Single read: push read addr=0x12 at T. Expect cache_re=1 only at T+2, cache_addr=0x12 held. Bench drives done=1 with cache_rdata=0xA5 at T+4. Expect resp_valid=1, resp_we=0, resp_rdata=0xA5 at T+5, then busy=0 at T+6.
- Write: push write addr=0x03, wdata=0x7E. Expect one cache_we pulse with cache_wdata=0x7E stable until done. Response has resp_we=1, resp_rdata=0.
- Fill/backpressure: push 4 requests while op_in_progress=1. Expect req_ready=0 after the 4th and no issue. Drop op_in_progress. Expect 4 responses in FIFO order, each separated by at least 4 cycles, with req_ready returning 1 after the first RESP.
- Timeout: issue a read and never assert done. Expect resp_valid with resp_err=1 exactly TIMEOUT_CYCLES cycles after entering WAIT, err_sticky=1 until err_clear. Done asserted on the terminal cycle gives resp_err=0.
- Stray done: pulse done in IDLE and in ISSUE. Expect no resp_valid and no state change.
